// File: rtl/result_buffer_mem_if.sv
// Bundle between the dot-product engine/downstream reader (master) and the
// result buffer (slave): result handshake, frame control, read port, status.
interface result_buffer_mem_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH),
    parameter int ADDR_WIDTH   = 6
);
    logic signed [RESULT_WIDTH-1:0] res_data;
    logic                           res_valid;
    logic                           res_ready;
    logic                           proc_done;
    logic                           clear;
    logic                           rd_en;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic                           rd_valid;
    logic [ADDR_WIDTH:0]            wr_count;
    logic                           buf_full;
    logic                           buf_done;
    logic                           busy;
    logic                           sat_sticky;

    modport master (
        output res_data, res_valid, proc_done, clear, rd_en, rd_addr,
        input  res_ready, rd_data, rd_valid, wr_count, buf_full, buf_done, busy, sat_sticky
    );

    modport slave (
        input  res_data, res_valid, proc_done, clear, rd_en, rd_addr,
        output res_ready, rd_data, rd_valid, wr_count, buf_full, buf_done, busy, sat_sticky
    );
endinterface

// File: rtl/result_buffer_mem.sv
// Result store: scales/narrows dot-product results into a sequential RAM frame.
// Optional macro RESULT_SAT_EN selects saturating narrowing (default: wrapping truncation).
module result_buffer_mem #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH),
    parameter int ADDR_WIDTH   = 6,
    parameter int DEPTH        = 64,
    parameter int SHIFT        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    result_buffer_mem_if.slave    bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    localparam logic signed [RESULT_WIDTH-1:0] SAT_MAX =
        {{(RESULT_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [RESULT_WIDTH-1:0] SAT_MIN =
        {{(RESULT_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Returns {saturated_flag, stored_word} for an already-shifted result.
    function automatic logic [DATA_WIDTH:0] narrow_word(input logic signed [RESULT_WIDTH-1:0] s);
        logic [DATA_WIDTH:0] r;
`ifdef RESULT_SAT_EN
        if (s > SAT_MAX) begin
            r = {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        end else if (s < SAT_MIN) begin
            r = {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        end else begin
            r = {1'b0, s[DATA_WIDTH-1:0]};
        end
`else
        r = {1'b0, s[DATA_WIDTH-1:0]};
`endif
        return r;
    endfunction

    logic [1:0]                     state_q, state_d;
    logic [ADDR_WIDTH:0]            wr_count_q, wr_count_d;
    logic                           sat_sticky_q, sat_sticky_d;
    logic                           res_ready_q, buf_full_q, busy_q, done_q;
    logic [DATA_WIDTH-1:0]          rd_data_q;
    logic                           rd_valid_q;
    logic [DATA_WIDTH-1:0]          mem_q [DEPTH];

    logic signed [RESULT_WIDTH-1:0] shifted_s;
    logic [DATA_WIDTH:0]            narrow_s;
    logic                           accept_s;
    logic                           wr_en_s;

    // Scale and narrow the incoming result.
    always_comb begin
        shifted_s = bus.res_data >>> SHIFT;
        narrow_s  = narrow_word(shifted_s);
    end

    // Frame control: clear wins over accept and proc_done on the same edge.
    always_comb begin
        state_d      = state_q;
        wr_count_d   = wr_count_q;
        sat_sticky_d = sat_sticky_q;
        wr_en_s      = 1'b0;
        accept_s     = bus.res_valid && res_ready_q;
        if (bus.clear) begin
            state_d      = ST_IDLE;
            wr_count_d   = {(ADDR_WIDTH + 1){1'b0}};
            sat_sticky_d = 1'b0;
        end else begin
            if (accept_s) begin
                wr_en_s      = 1'b1;
                wr_count_d   = wr_count_q + ONE_C;
                sat_sticky_d = sat_sticky_q | narrow_s[DATA_WIDTH];
            end else begin
                wr_en_s      = 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.proc_done) begin
                        state_d = ST_DONE;
                    end else if (accept_s) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (bus.proc_done) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, count and status flags; flags are decoded from next state so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_count_q   <= {(ADDR_WIDTH + 1){1'b0}};
            sat_sticky_q <= 1'b0;
            res_ready_q  <= 1'b1;
            buf_full_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_count_q   <= wr_count_d;
            sat_sticky_q <= sat_sticky_d;
            res_ready_q  <= (state_d != ST_DONE) && (wr_count_d != DEPTH_C);
            buf_full_q   <= (wr_count_d == DEPTH_C);
            busy_q       <= (state_d == ST_FILL);
            done_q       <= (state_d == ST_DONE);
        end
    end

    // Result RAM; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_count_q[ADDR_WIDTH-1:0]] <= narrow_s[DATA_WIDTH-1:0];
        end
    end

    // Registered read port; addresses not yet written in this frame read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= {DATA_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                if ({1'b0, bus.rd_addr} < wr_count_q) begin
                    rd_data_q <= mem_q[bus.rd_addr];
                end else begin
                    rd_data_q <= {DATA_WIDTH{1'b0}};
                end
            end else begin
                rd_data_q <= rd_data_q;
            end
        end
    end

    assign bus.res_ready  = res_ready_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.buf_full   = buf_full_q;
    assign bus.buf_done   = done_q;
    assign bus.busy       = busy_q;
    assign bus.sat_sticky = sat_sticky_q;
endmodule

// File: tb/tb_result_buffer_mem.sv
// Directed bench for result_buffer_mem: one instance with SHIFT=0, one with SHIFT=2.
module tb_result_buffer_mem;
    localparam int DW = 8;
    localparam int RW = 18;
    localparam int AW = 6;

`ifdef RESULT_SAT_EN
    localparam logic [7:0] EXP_300 = 8'h7F;
    localparam logic [7:0] EXP_M200 = 8'h80;
    localparam logic       EXP_STICKY = 1'b1;
`else
    localparam logic [7:0] EXP_300 = 8'h2C;
    localparam logic [7:0] EXP_M200 = 8'h38;
    localparam logic       EXP_STICKY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    result_buffer_mem_if #(.DATA_WIDTH(DW), .VECTOR_WIDTH(4), .RESULT_WIDTH(RW), .ADDR_WIDTH(AW)) if0 ();
    result_buffer_mem_if #(.DATA_WIDTH(DW), .VECTOR_WIDTH(4), .RESULT_WIDTH(RW), .ADDR_WIDTH(AW)) if2 ();

    result_buffer_mem #(.DATA_WIDTH(DW), .VECTOR_WIDTH(4), .ADDR_WIDTH(AW), .DEPTH(64), .SHIFT(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    result_buffer_mem #(.DATA_WIDTH(DW), .VECTOR_WIDTH(4), .ADDR_WIDTH(AW), .DEPTH(64), .SHIFT(2))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic acc0(input int v);
        if0.res_data  = v[RW-1:0];
        if0.res_valid = 1'b1;
        tick();
        if0.res_valid = 1'b0;
    endtask

    task automatic acc2(input int v);
        if2.res_data  = v[RW-1:0];
        if2.res_valid = 1'b1;
        tick();
        if2.res_valid = 1'b0;
    endtask

    task automatic rd0(input int a, output logic [7:0] d, output logic v);
        if0.rd_en   = 1'b1;
        if0.rd_addr = a[AW-1:0];
        tick();
        if0.rd_en   = 1'b0;
        d = if0.rd_data;
        v = if0.rd_valid;
    endtask

    task automatic rd2(input int a, output logic [7:0] d, output logic v);
        if2.rd_en   = 1'b1;
        if2.rd_addr = a[AW-1:0];
        tick();
        if2.rd_en   = 1'b0;
        d = if2.rd_data;
        v = if2.rd_valid;
    endtask

    task automatic clr0;
        if0.clear = 1'b1;
        tick();
        if0.clear = 1'b0;
    endtask

    logic [7:0] d;
    logic       v;
    int         acc_n;
    int         tmp;
    logic       rdy;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        if0.res_data = '0; if0.res_valid = 1'b0; if0.proc_done = 1'b0;
        if0.clear = 1'b0; if0.rd_en = 1'b0; if0.rd_addr = '0;
        if2.res_data = '0; if2.res_valid = 1'b0; if2.proc_done = 1'b0;
        if2.clear = 1'b0; if2.rd_en = 1'b0; if2.rd_addr = '0;

        #12;
        check_val("rst_ready",   32'(if0.res_ready), 32'd1);
        check_val("rst_rd_data", 32'(if0.rd_data), 32'd0);
        check_val("rst_rd_valid", 32'(if0.rd_valid), 32'd0);
        check_val("rst_wr_count", 32'(if0.wr_count), 32'd0);
        check_val("rst_flags",
                  32'({if0.buf_full, if0.buf_done, if0.busy, if0.sat_sticky}), 32'd0);
        rst_n = 1'b1;
        tick();

        // basic accept and read
        acc0(100);
        check_val("t1_count", 32'(if0.wr_count), 32'd1);
        check_val("t1_busy", 32'(if0.busy), 32'd1);
        check_val("t1_done", 32'(if0.buf_done), 32'd0);
        rd0(0, d, v);
        check_val("t1_rd_data", 32'(d), 32'd100);
        check_val("t1_rd_valid", 32'(v), 32'd1);
        tick();
        check_val("t1_rd_valid_pulse", 32'(if0.rd_valid), 32'd0);

        // narrowing: saturation or wrap
        clr0();
        check_val("t2_clr_count", 32'(if0.wr_count), 32'd0);
        acc0(300);
        acc0(-200);
        rd0(0, d, v);
        check_val("t2_pos", 32'(d), 32'(EXP_300));
        rd0(1, d, v);
        check_val("t2_neg", 32'(d), 32'(EXP_M200));
        check_val("t2_sticky", 32'(if0.sat_sticky), 32'(EXP_STICKY));
        clr0();
        check_val("t2_sticky_clr", 32'(if0.sat_sticky), 32'd0);

        // arithmetic right shift by 2
        acc2(403);
        acc2(-5);
        rd2(0, d, v);
        check_val("t3_shift_pos", 32'(d), 32'd100);
        rd2(1, d, v);
        check_val("t3_shift_neg", 32'(d), 32'hFE);
        check_val("t3_count", 32'(if2.wr_count), 32'd2);

        // stream until full
        acc_n = 0;
        for (int i = 0; i < 70; i++) begin
            tmp = acc_n + 1;
            if0.res_data  = tmp[RW-1:0];
            if0.res_valid = 1'b1;
            rdy = if0.res_ready;
            tick();
            if (rdy) acc_n++;
        end
        check_val("t4_accepted", 32'(acc_n), 32'd64);
        check_val("t4_count", 32'(if0.wr_count), 32'd64);
        check_val("t4_full", 32'(if0.buf_full), 32'd1);
        check_val("t4_ready", 32'(if0.res_ready), 32'd0);
        check_val("t4_busy", 32'(if0.busy), 32'd1);
        tick();
        tick();
        check_val("t4_held_count", 32'(if0.wr_count), 32'd64);
        rd0(63, d, v);
        check_val("t4_last_word", 32'(d), 32'd64);
        rd0(0, d, v);
        check_val("t4_first_word", 32'(d), 32'd1);
        if0.proc_done = 1'b1;
        tick();
        if0.proc_done = 1'b0;
        if0.res_valid = 1'b0;
        check_val("t4_done", 32'(if0.buf_done), 32'd1);
        check_val("t4_busy_off", 32'(if0.busy), 32'd0);
        clr0();
        check_val("t4_clr_count", 32'(if0.wr_count), 32'd0);
        check_val("t4_clr_ready", 32'(if0.res_ready), 32'd1);
        check_val("t4_clr_state", 32'({if0.buf_done, if0.busy, if0.buf_full}), 32'd0);

        // accept together with proc_done
        for (int i = 0; i < 5; i++) acc0(10 + i);
        if0.res_data  = 18'd77;
        if0.res_valid = 1'b1;
        if0.proc_done = 1'b1;
        tick();
        if0.proc_done = 1'b0;
        if0.res_valid = 1'b0;
        check_val("t5_count", 32'(if0.wr_count), 32'd6);
        check_val("t5_done", 32'(if0.buf_done), 32'd1);
        check_val("t5_ready", 32'(if0.res_ready), 32'd0);
        acc0(88);
        check_val("t5_no_accept", 32'(if0.wr_count), 32'd6);
        if0.proc_done = 1'b1;
        tick();
        if0.proc_done = 1'b0;
        check_val("t5_done_hold", 32'(if0.buf_done), 32'd1);
        rd0(6, d, v);
        check_val("t5_rd_unwritten", 32'(d), 32'd0);
        check_val("t5_rd_unwritten_v", 32'(v), 32'd1);
        rd0(5, d, v);
        check_val("t5_rd_last", 32'(d), 32'd77);
        clr0();

        // reset mid-fill
        for (int i = 0; i < 10; i++) acc0(3 * i);
        check_val("t6_count10", 32'(if0.wr_count), 32'd10);
        rd0(9, d, v);
        check_val("t6_rd9", 32'(d), 32'd27);
        rst_n = 1'b0;
        #2;
        check_val("t6_rst_count", 32'(if0.wr_count), 32'd0);
        check_val("t6_rst_busy", 32'(if0.busy), 32'd0);
        check_val("t6_rst_ready", 32'(if0.res_ready), 32'd1);
        check_val("t6_rst_rd", 32'({if0.rd_data, if0.rd_valid}), 32'd0);
        rst_n = 1'b1;
        tick();
        acc0(55);
        check_val("t6_new_count", 32'(if0.wr_count), 32'd1);
        rd0(0, d, v);
        check_val("t6_new_word", 32'(d), 32'd55);

        // clear beats accept
        if0.res_data  = 18'd99;
        if0.res_valid = 1'b1;
        if0.clear     = 1'b1;
        tick();
        if0.clear     = 1'b0;
        if0.res_valid = 1'b0;
        check_val("t6_clr_acc_count", 32'(if0.wr_count), 32'd0);
        check_val("t6_clr_acc_busy", 32'(if0.busy), 32'd0);
        rd0(0, d, v);
        check_val("t6_clr_acc_rd", 32'(d), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
